signed_num_parser: RTL and testbench
====================================

Name: signed_num_parser

Overview:
- Streaming ASCII-decimal-to-binary converter between the UART receiver byte output and the top-level matrix command FSM.
- Successor to the existing unsigned command parser. Adds:
  - a leading '-' for negative operands;
  - parametrised output width;
  - configurable delimiters;
  - overflow detection with saturate/reject modes;
  - per-token error reporting;
  - a running count of emitted numbers.
- Emits one two's-complement number per delimited token.

Parameters:
- DATA_W, 16: output width in bits, two's complement; legal range 4..32.
- SATURATE, 1: 1 = an overflowed token emits the clamped value plus an overflow pulse; 0 = an overflowed token is rejected with an error pulse.
- COMMA_DELIM, 1: 1 = ',' (0x2C) also acts as a delimiter.
- CNT_W, 8: width of the emitted-number counter.

Ports:
- sys_clk_in, input, 1: system clock.
- sys_rst_n, input, 1: asynchronous active-low reset.
- rx_data, input, 8: received byte.
- rx_valid, input, 1: one-cycle strobe qualifying rx_data.
- clear, input, 1: synchronous abort. Drops the current token and zeroes num_count.
- number_out, output, DATA_W: parsed signed value. Holds its last value between pulses.
- number_valid, output, 1: one-cycle pulse; number_out is valid in that cycle.
- overflow, output, 1: one-cycle pulse coincident with number_valid when the value was clamped.
- error, output, 1: one-cycle pulse when a token is rejected.
- busy, output, 1: high while a token is partially received (ST_SIGN, ST_DIGIT or ST_SKIP).
- num_count, output, CNT_W: count of number_valid pulses. Wraps at 2^CNT_W.

Behaviour:
- Reset (async, sys_rst_n low): state ST_IDLE; number_out = 0; number_valid = overflow = error = 0; busy = 0; num_count = 0; internal magnitude, negative flag and overflow flag cleared.
- Byte classes:
  - digit: 0x30..0x39;
  - minus: 0x2D;
  - delimiter: 0x20, 0x0D, 0x0A, plus 0x2C when COMMA_DELIM = 1;
  - everything else is invalid.
- Bytes are consumed only in cycles with rx_valid = 1. In other cycles the state holds.
- ST_IDLE:
  - delimiter: ignored, so runs of spaces or CR/LF produce nothing;
  - minus: set neg, go to ST_SIGN;
  - digit: mag = digit value, go to ST_DIGIT;
  - invalid: go to ST_SKIP.
- ST_SIGN:
  - digit: mag = digit value, go to ST_DIGIT;
  - delimiter: error pulse, go to ST_IDLE (a lone '-' is an error);
  - minus or invalid: go to ST_SKIP.
- ST_DIGIT:
  - digit: next = mag*10 + d, computed at width DATA_W+4.
  - Limit is 2^(DATA_W-1) when neg, else 2^(DATA_W-1)-1.
  - If next > limit: mag = limit and the ovf flag is set sticky for the token. Otherwise mag = next.
  - The clamp means mag never wraps, for any number of digits. Leading zeros are accepted.
  - delimiter, when ovf = 0 or SATURATE = 1:
    - number_out = neg ? -mag : mag, truncated to DATA_W (-2^(DATA_W-1) is representable);
    - number_valid pulses; overflow pulses if ovf = 1; num_count increments; go to ST_IDLE.
  - delimiter, when ovf = 1 and SATURATE = 0: error pulse only; number_out unchanged; go to ST_IDLE.
  - minus or invalid: go to ST_SKIP.
- ST_SKIP: discard bytes until a delimiter, then error pulse and go to ST_IDLE. An error is emitted exactly once per bad token.
- Latency: outputs are registered. number_valid, overflow and error assert in the cycle after the rx_valid cycle that carried the delimiter, for exactly one cycle.
- At most one of {number_valid, error} is high in any cycle.
- Leaving any state for ST_IDLE clears mag, neg and ovf.
- clear:
  - has priority over rx_valid in the same cycle;
  - forces ST_IDLE, clears mag, neg, ovf and num_count;
  - suppresses any pulse that byte would have produced.
  - number_out keeps its value.
- Reset mid-token: immediate return to the reset state. No pulse is emitted.
- busy is combinational from the state: busy = (state != ST_IDLE).

Test Plan:
1. DATA_W = 16, SATURATE = 1. Send "-30 " then "40 " -> number_out 0xFFE2 with number_valid, then 0x0028 with number_valid; num_count = 2; no error and no overflow pulses.
2. Send "32767 ", "32768 ", "-32768 ", "-40000 " ->
   - 0x7FFF, overflow = 0;
   - 0x7FFF, overflow = 1;
   - 0x8000, overflow = 0;
   - 0x8000, overflow = 1.
3. SATURATE = 0, send "99999 " -> error pulse, no number_valid, number_out unchanged, num_count unchanged.
4. Send "  7\r\n,12," with COMMA_DELIM = 1 -> exactly two valids, 7 then 12. Delimiter runs produce nothing.
5. Send "1a2 ", "- ", "--5 ", "5-3 " -> exactly four error pulses, each one cycle after its terminating delimiter. No valids.
6. Send "12", then assert clear; then send " 3 "; then assert clear coincident with the rx_valid of a delimiter that would otherwise complete "4" -> no pulse for 12, valid 3 (num_count = 1), no pulse for 4, num_count = 0. Asserting sys_rst_n low mid-token returns all outputs to their reset values.

Source files
------------

// File: rtl/signed_num_parser.sv
// ---------------------------------------------------------------------------
// signed_num_parser
// Converts a stream of ASCII decimal tokens into two's-complement numbers.
// A token is an optional leading '-', one or more digits, and a delimiter
// (space, CR, LF and optionally ','). Each accepted token pulses
// number_valid. A malformed token, or an overflowed one when saturation is
// disabled, pulses error exactly once.
//
// Ports
//   sys_clk_in   in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   rx_data      in   received byte
//   rx_valid     in   one-cycle strobe qualifying rx_data
//   clear        in   synchronous abort: drops the token, zeroes num_count
//   number_out   out  parsed signed value, held between pulses
//   number_valid out  one-cycle pulse, number_out valid
//   overflow     out  one-cycle pulse with number_valid when value clamped
//   error        out  one-cycle pulse when a token is rejected
//   busy         out  a token is partially received
//   num_count    out  count of number_valid pulses (wrapping)
// ---------------------------------------------------------------------------
module signed_num_parser #(
    parameter int DATA_W      = 16,
    parameter int SATURATE    = 1,
    parameter int COMMA_DELIM = 1,
    parameter int CNT_W       = 8
) (
    input  logic              sys_clk_in,
    input  logic              sys_rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              clear,
    output logic [DATA_W-1:0] number_out,
    output logic              number_valid,
    output logic              overflow,
    output logic              error,
    output logic              busy,
    output logic [CNT_W-1:0]  num_count
);

    // Four guard bits hold mag*10 + 9 without wrapping, since mag never
    // exceeds 2^(DATA_W-1).
    localparam int EXT_W = DATA_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SIGN,
        ST_DIGIT,
        ST_SKIP
    } state_t;

    state_t              r_state;
    logic [EXT_W-1:0]    r_mag;
    logic                r_neg;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_number;
    logic                r_valid;
    logic                r_ovf_pulse;
    logic                r_error;
    logic [CNT_W-1:0]    r_count;

    logic                w_is_digit;
    logic                w_is_minus;
    logic                w_is_delim;
    logic [EXT_W-1:0]    w_digit;
    logic [EXT_W-1:0]    w_next;
    logic [EXT_W-1:0]    w_limit;
    logic [DATA_W-1:0]   w_mag_lo;
    logic [DATA_W-1:0]   w_signed;

    assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_minus = (rx_data == 8'h2D);
    assign w_is_delim = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A) ||
                        ((COMMA_DELIM != 0) && (rx_data == 8'h2C));

    assign w_digit = EXT_W'(rx_data[3:0]);
    assign w_next  = (r_mag << 3) + (r_mag << 1) + w_digit;

    // Negative tokens may reach one further than positive ones.
    assign w_limit = r_neg ? (EXT_W'(1) << (DATA_W - 1))
                           : ((EXT_W'(1) << (DATA_W - 1)) - EXT_W'(1));

    // -2^(DATA_W-1) negates to itself in DATA_W bits, which is exactly right.
    assign w_mag_lo = r_mag[DATA_W-1:0];
    assign w_signed = r_neg ? -w_mag_lo : w_mag_lo;

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_mag       <= '0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_number    <= '0;
            r_valid     <= 1'b0;
            r_ovf_pulse <= 1'b0;
            r_error     <= 1'b0;
            r_count     <= '0;
        end else begin
            r_valid     <= 1'b0;
            r_ovf_pulse <= 1'b0;
            r_error     <= 1'b0;

            if (clear) begin
                r_state <= ST_IDLE;
                r_mag   <= '0;
                r_neg   <= 1'b0;
                r_ovf   <= 1'b0;
                r_count <= '0;
            end else if (rx_valid) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_is_minus) begin
                            r_neg   <= 1'b1;
                            r_state <= ST_SIGN;
                        end else if (w_is_digit) begin
                            r_mag   <= w_digit;
                            r_state <= ST_DIGIT;
                        end else if (!w_is_delim) begin
                            r_state <= ST_SKIP;
                        end
                    end

                    ST_SIGN: begin
                        if (w_is_digit) begin
                            r_mag   <= w_digit;
                            r_state <= ST_DIGIT;
                        end else if (w_is_delim) begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                            r_mag   <= '0;
                            r_neg   <= 1'b0;
                            r_ovf   <= 1'b0;
                        end else begin
                            r_state <= ST_SKIP;
                        end
                    end

                    ST_DIGIT: begin
                        if (w_is_digit) begin
                            // Clamp keeps mag bounded for arbitrarily long tokens.
                            if (w_next > w_limit) begin
                                r_mag <= w_limit;
                                r_ovf <= 1'b1;
                            end else begin
                                r_mag <= w_next;
                            end
                        end else if (w_is_delim) begin
                            if (!r_ovf || (SATURATE != 0)) begin
                                r_number    <= w_signed;
                                r_valid     <= 1'b1;
                                r_ovf_pulse <= r_ovf;
                                r_count     <= r_count + CNT_W'(1);
                            end else begin
                                r_error <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                            r_mag   <= '0;
                            r_neg   <= 1'b0;
                            r_ovf   <= 1'b0;
                        end else begin
                            r_state <= ST_SKIP;
                        end
                    end

                    ST_SKIP: begin
                        if (w_is_delim) begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                            r_mag   <= '0;
                            r_neg   <= 1'b0;
                            r_ovf   <= 1'b0;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign number_out   = r_number;
    assign number_valid = r_valid;
    assign overflow     = r_ovf_pulse;
    assign error        = r_error;
    assign num_count    = r_count;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_signed_num_parser.sv
// ---------------------------------------------------------------------------
// tb_signed_num_parser
// Drives the same byte stream into a saturating and a rejecting instance of
// signed_num_parser. Expected pulses are queued per instance when the
// terminating byte is driven, and popped by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_signed_num_parser;

    typedef struct {
        int          kind;   // 1 = number_valid, 2 = error
        logic [15:0] val;
        logic        ovf;
        int          stamp;  // negedge index at which the pulse must appear
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        clear;

    logic [15:0] no_s, no_r;
    logic        nv_s, nv_r, ov_s, ov_r, er_s, er_r, bz_s, bz_r;
    logic [7:0]  nc_s, nc_r;

    int          n_cmp;
    int          n_bad;
    int          ncnt;
    ev_t         q0[$];
    ev_t         q1[$];
    logic [15:0] lv0, lv1;
    int          cnt0, cnt1;

    signed_num_parser #(.DATA_W(16), .SATURATE(1), .COMMA_DELIM(1), .CNT_W(8)) u_sat (
        .sys_clk_in(clk), .sys_rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear(clear), .number_out(no_s), .number_valid(nv_s), .overflow(ov_s),
        .error(er_s), .busy(bz_s), .num_count(nc_s)
    );

    signed_num_parser #(.DATA_W(16), .SATURATE(0), .COMMA_DELIM(1), .CNT_W(8)) u_rej (
        .sys_clk_in(clk), .sys_rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear(clear), .number_out(no_r), .number_valid(nv_r), .overflow(ov_r),
        .error(er_r), .busy(bz_r), .num_count(nc_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mon(input int i, input logic nv, input logic er, input logic ov,
                       input logic [15:0] no);
        ev_t e;
        bit  have;
        have = 0;
        if (nv || er) begin
            if (i == 0 && q0.size() > 0) begin
                e = q0.pop_front();
                have = 1;
            end else if (i == 1 && q1.size() > 0) begin
                e = q1.pop_front();
                have = 1;
            end
            if (!have) begin
                chk($sformatf("unexpected_pulse_%0d", i), {30'd0, nv, er}, 32'd0);
            end else begin
                chk($sformatf("pulse_kind_%0d", i), nv ? 32'd1 : 32'd2, e.kind);
                chk($sformatf("pulse_time_%0d", i), ncnt, e.stamp);
                chk($sformatf("number_out_%0d", i), {16'd0, no}, {16'd0, e.val});
                chk($sformatf("overflow_%0d", i), {31'd0, ov}, {31'd0, e.ovf});
                chk($sformatf("exclusive_%0d", i), {31'd0, nv & er}, 32'd0);
            end
        end else if (ov) begin
            chk($sformatf("stray_overflow_%0d", i), {31'd0, ov}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        ncnt++;
        if (rst_n) begin
            mon(0, nv_s, er_s, ov_s, no_s);
            mon(1, nv_r, er_r, ov_r, no_r);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic with_clear);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        clear    = with_clear;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // Sends a token; k = 0 none, 1 valid, 2 error for each instance.
    task automatic tok(input string s,
                       input int k0, input logic [15:0] v0, input logic o0,
                       input int k1, input logic [15:0] v1, input logic o1);
        ev_t e;
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
        e.stamp = ncnt + 1;
        if (k0 != 0) begin
            e.kind = k0;
            e.ovf  = (k0 == 1) ? o0 : 1'b0;
            if (k0 == 1) begin
                lv0 = v0;
                cnt0++;
            end
            e.val = lv0;
            q0.push_back(e);
        end
        if (k1 != 0) begin
            e.kind = k1;
            e.ovf  = (k1 == 1) ? o1 : 1'b0;
            if (k1 == 1) begin
                lv1 = v1;
                cnt1++;
            end
            e.val = lv1;
            q1.push_back(e);
        end
    endtask

    task automatic chk_counts(input string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_count_sat"}, {24'd0, nc_s}, cnt0 % 256);
        chk({tag, "_count_rej"}, {24'd0, nc_r}, cnt1 % 256);
        chk({tag, "_q_sat"}, q0.size(), 0);
        chk({tag, "_q_rej"}, q1.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_s"}, {16'd0, no_s}, 32'd0);
        chk({tag, "_out_r"}, {16'd0, no_r}, 32'd0);
        chk({tag, "_pulses_s"}, {29'd0, nv_s, ov_s, er_s}, 32'd0);
        chk({tag, "_pulses_r"}, {29'd0, nv_r, ov_r, er_r}, 32'd0);
        chk({tag, "_busy"}, {30'd0, bz_s, bz_r}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, nc_s, nc_r}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; ncnt = 0;
        lv0 = '0; lv1 = '0; cnt0 = 0; cnt1 = 0;
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; clear = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Signed basics
        tok("-30 ", 1, 16'hFFE2, 0, 1, 16'hFFE2, 0);
        tok("40 ",  1, 16'h0028, 0, 1, 16'h0028, 0);
        chk_counts("basic");

        // Range edges: saturate vs reject
        tok("32767 ",  1, 16'h7FFF, 0, 1, 16'h7FFF, 0);
        tok("32768 ",  1, 16'h7FFF, 1, 2, 16'h0000, 0);
        tok("-32768 ", 1, 16'h8000, 0, 1, 16'h8000, 0);
        tok("-40000 ", 1, 16'h8000, 1, 2, 16'h0000, 0);
        tok("99999 ",  1, 16'h7FFF, 1, 2, 16'h0000, 0);
        chk_counts("range");

        // Delimiter runs, CR/LF and comma
        tok("  7\015", 1, 16'h0007, 0, 1, 16'h0007, 0);
        tok("\n,12,",  1, 16'h000C, 0, 1, 16'h000C, 0);
        tok("007 ",    1, 16'h0007, 0, 1, 16'h0007, 0);
        chk_counts("delim");

        // Malformed tokens: one error each
        tok("1a2 ", 2, 16'h0, 0, 2, 16'h0, 0);
        tok("- ",   2, 16'h0, 0, 2, 16'h0, 0);
        tok("--5 ", 2, 16'h0, 0, 2, 16'h0, 0);
        tok("5-3 ", 2, 16'h0, 0, 2, 16'h0, 0);
        chk_counts("bad");

        // clear drops a partial token and zeroes the counter
        tok("12", 0, 16'h0, 0, 0, 16'h0, 0);
        chk("busy_mid_token", {30'd0, bz_s, bz_r}, 32'd3);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        cnt0 = 0; cnt1 = 0;
        chk("busy_after_clear", {30'd0, bz_s, bz_r}, 32'd0);
        tok(" 3 ", 1, 16'h0003, 0, 1, 16'h0003, 0);
        chk_counts("after_clear");

        // clear coincident with the completing delimiter wins
        tok("4", 0, 16'h0, 0, 0, 16'h0, 0);
        send_byte(8'h20, 1'b1);
        cnt0 = 0; cnt1 = 0;
        chk_counts("clear_vs_delim");
        chk("out_kept_s", {16'd0, no_s}, {16'd0, lv0});
        chk("out_kept_r", {16'd0, no_r}, {16'd0, lv1});

        // Reset mid-token
        tok("-5", 0, 16'h0, 0, 0, 16'h0, 0);
        chk("busy_before_reset", {30'd0, bz_s, bz_r}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        lv0 = '0; lv1 = '0; cnt0 = 0; cnt1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tok(" ",   0, 16'h0, 0, 0, 16'h0, 0);
        tok("8 ",  1, 16'h0008, 0, 1, 16'h0008, 0);
        chk_counts("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
